// File: rtl/video_path_select.sv
// ---------------------------------------------------------------------------
// video_path_select
//
// Selects one of N_IN processed video streams (all on the rx pixel clock) for
// the HDMI transmitter. Each stream first passes through its own delay line,
// so every stream reaches the mux with the same total latency LAT_MAX. A new
// selection is applied only at a frame boundary, which is detected on aligned
// stream 0. After a switch the picture is forced black for BLANK_FRAMES
// frames. The syncs keep running while the picture is black.
//
// Ports
//   clk           pixel clock (rx_clk)
//   rst           synchronous, active-high reset
//   dv_i/hs_i/vs_i  per-stream data valid / hsync / vsync, bit k = stream k
//   r_i/g_i/b_i   per-stream colour, stream k at [k*DW +: DW]
//   sel_i         requested stream; values >= N_IN select "black"
//   dv_o..b_o     registered selected stream
//   active_sel_o  selection currently applied
//   pending_o     a requested selection is waiting for a frame boundary
//   blank_o       output currently forced black
//   frame_cnt_o   frame boundaries seen since reset (wraps)
// ---------------------------------------------------------------------------
module video_path_select #(
   parameter int                DW           = 8,
   parameter int                N_IN         = 4,
   parameter logic [N_IN*8-1:0] LAT          = '0,
   parameter int                LAT_MAX      = 16,
   parameter bit                VS_POL       = 1'b1,
   parameter int                BLANK_FRAMES = 1,
   parameter int                SW           = $clog2(N_IN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_IN-1:0]    dv_i,
   input  logic [N_IN-1:0]    hs_i,
   input  logic [N_IN-1:0]    vs_i,
   input  logic [N_IN*DW-1:0] r_i,
   input  logic [N_IN*DW-1:0] g_i,
   input  logic [N_IN*DW-1:0] b_i,
   input  logic [SW-1:0]      sel_i,
   output logic               dv_o,
   output logic               hs_o,
   output logic               vs_o,
   output logic [DW-1:0]      r_o,
   output logic [DW-1:0]      g_o,
   output logic [DW-1:0]      b_o,
   output logic [SW-1:0]      active_sel_o,
   output logic               pending_o,
   output logic               blank_o,
   output logic [15:0]        frame_cnt_o
);

   // One pixel word: {dv, hs, vs, r, g, b}; colour occupies the low 3*DW bits.
   localparam int PW = 3 + 3 * DW;
   // Blank counter must hold BLANK_FRAMES; keep at least one bit when it is 0.
   localparam int CW = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_FRAMES);

   if (N_IN < 2 || N_IN > 8) begin : g_bad_n_in
      $error("video_path_select: N_IN must be in 2..8");
   end

   // ------------------------------------------------------------------------
   // Latency alignment: stream k is delayed by LAT_MAX - LAT[k] clocks.
   // ------------------------------------------------------------------------
   logic [PW-1:0] aligned [N_IN];

   for (genvar k = 0; k < N_IN; k++) begin : g_align
      localparam int D = LAT_MAX - int'(LAT[k*8 +: 8]);

      logic [PW-1:0] din;
      assign din = {dv_i[k], hs_i[k], vs_i[k],
                    r_i[k*DW +: DW], g_i[k*DW +: DW], b_i[k*DW +: DW]};

      if (D < 0) begin : g_bad_lat
         $error("video_path_select: LAT_MAX is smaller than a stream latency");
         assign aligned[k] = '0;
      end else if (D == 0) begin : g_wire
         assign aligned[k] = din;
      end else begin : g_dly
         logic [PW-1:0] dly [D];

         // NOTE: the delay lines are cleared on reset so the first frame after
         // reset starts from a known (black, syncs inactive) history; this
         // keeps them out of RAM inference, which is acceptable at these depths.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < D; i++) dly[i] <= '0;
            end else begin
               dly[0] <= din;
               for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
            end
         end

         assign aligned[k] = dly[D-1];
      end
   end

   // ------------------------------------------------------------------------
   // Frame boundary and selection control
   // ------------------------------------------------------------------------
   logic            vs0_a;
   logic            vs0_prev;
   logic            boundary;
   logic [SW-1:0]   sel_q;
   logic [SW-1:0]   active_sel;
   logic            pending;
   logic [CW-1:0]   blank_cnt;
   logic [15:0]     frame_cnt_q;
   logic [PW-1:0]   out_word;

   logic [SW-1:0]   sel_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic            blank_nxt;
   logic            sel_ok;
   logic [PW-1:0]   mux_word;

   // Aligned vsync of every stream coincides, so stream 0 stands for all.
   assign vs0_a    = aligned[0][PW-3];
   assign boundary = (vs0_a == VS_POL) && (vs0_prev != VS_POL);
   assign pending  = (sel_q != active_sel);

   // The mux works on next-state selection/blanking so the output register
   // already shows the new source (black if blanking) on the boundary edge.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      sel_nxt  = active_sel;
      cnt_nxt  = blank_cnt;
      mux_word = aligned[0];
      sel_ok   = 1'b0;

      if (boundary && pending) begin
         sel_nxt = sel_q;
         cnt_nxt = BLANK_LOAD;
      end else if (boundary && blank_cnt != '0) begin
         cnt_nxt = blank_cnt - CW'(1);
      end

      blank_nxt = (cnt_nxt != '0);

      for (int k = 0; k < N_IN; k++) begin
         if (sel_nxt == SW'(k)) begin
            mux_word = aligned[k];
            sel_ok   = 1'b1;
         end
      end

      // Invalid selection keeps stream 0 syncs; either case zeroes colour.
      if (blank_nxt || !sel_ok) mux_word[3*DW-1:0] = '0;
   end

   // NOTE: all state here is sequential and uses non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs0_prev    <= 1'b0;
         sel_q       <= '0;
         active_sel  <= '0;
         blank_cnt   <= '0;
         frame_cnt_q <= '0;
         out_word    <= '0;
      end else begin
         vs0_prev    <= vs0_a;
         sel_q       <= sel_i;
         active_sel  <= sel_nxt;
         blank_cnt   <= cnt_nxt;
         frame_cnt_q <= frame_cnt_q + 16'(boundary);
         out_word    <= mux_word;
      end
   end

   assign {dv_o, hs_o, vs_o, r_o, g_o, b_o} = out_word;
   assign active_sel_o = active_sel;
   assign pending_o    = pending;
   assign blank_o      = (blank_cnt != '0);
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_video_path_select.sv
// ---------------------------------------------------------------------------
// Directed bench for video_path_select.
// One source timing (64-clock frames, 16-clock lines, vsync on the last line)
// feeds four streams, stream k delayed by lat_tab[k]. Output during cycle j
// must equal the selected stream's value for source index j-9.
// Frame boundaries reach the output on cycles 57 + 64*f.
// u_dut1 uses BLANK_FRAMES=1, u_dut2 uses BLANK_FRAMES=2.
// ---------------------------------------------------------------------------
module tb_video_path_select;

   localparam int DW   = 8;
   localparam int N_IN = 4;
   localparam int SW   = 3;
   localparam logic [31:0] LAT_P = {8'd8, 8'd5, 8'd3, 8'd0};
   localparam int LAT_MAX = 8;

   int lat_tab [4] = '{0, 3, 5, 8};

   logic              clk;
   logic              rst;
   logic [N_IN-1:0]   dv_i, hs_i, vs_i;
   logic [N_IN*DW-1:0] r_i, g_i, b_i;
   logic [SW-1:0]     sel1, sel2;

   logic              dv_o1, hs_o1, vs_o1, pending1, blank1;
   logic [DW-1:0]     r_o1, g_o1, b_o1;
   logic [SW-1:0]     active1;
   logic [15:0]       frame_cnt1;

   logic              dv_o2, hs_o2, vs_o2, pending2, blank2;
   logic [DW-1:0]     r_o2, g_o2, b_o2;
   logic [SW-1:0]     active2;
   logic [15:0]       frame_cnt2;

   int n_checks = 0;
   int n_errors = 0;

   video_path_select #(
      .DW(DW), .N_IN(N_IN), .LAT(LAT_P), .LAT_MAX(LAT_MAX),
      .VS_POL(1'b1), .BLANK_FRAMES(1)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .sel_i(sel1),
      .dv_o(dv_o1), .hs_o(hs_o1), .vs_o(vs_o1),
      .r_o(r_o1), .g_o(g_o1), .b_o(b_o1),
      .active_sel_o(active1), .pending_o(pending1),
      .blank_o(blank1), .frame_cnt_o(frame_cnt1)
   );

   video_path_select #(
      .DW(DW), .N_IN(N_IN), .LAT(LAT_P), .LAT_MAX(LAT_MAX),
      .VS_POL(1'b1), .BLANK_FRAMES(2)
   ) u_dut2 (
      .clk(clk), .rst(rst),
      .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .sel_i(sel2),
      .dv_o(dv_o2), .hs_o(hs_o2), .vs_o(vs_o2),
      .r_o(r_o2), .g_o(g_o2), .b_o(b_o2),
      .active_sel_o(active2), .pending_o(pending2),
      .blank_o(blank2), .frame_cnt_o(frame_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // Stream k's word {dv,hs,vs,r,g,b} for source index m.
   function automatic logic [26:0] stream_vec(int k, int m);
      int ph;
      logic dv, hs, vs;
      logic [7:0] r, g, b;
      if (m < 0) return '0;
      ph = m % 64;
      vs = (ph >= 48);
      hs = ((ph % 16) < 2);
      dv = ((ph % 16) >= 4) && (ph < 48);
      r  = 8'(m + 50 * k);
      g  = 8'(m) ^ 8'(16 * k + 3);
      b  = 8'(16 * k + 1);
      return {dv, hs, vs, r, g, b};
   endfunction

   function automatic logic [26:0] black(logic [26:0] v);
      return {v[26:24], 24'h0};
   endfunction

   task automatic drive(input int j);
      logic [26:0] v;
      for (int k = 0; k < N_IN; k++) begin
         v = stream_vec(k, j - lat_tab[k]);
         dv_i[k] = v[26];
         hs_i[k] = v[25];
         vs_i[k] = v[24];
         r_i[k*DW +: DW] = v[23:16];
         g_i[k*DW +: DW] = v[15:8];
         b_i[k*DW +: DW] = v[7:0];
      end
   endtask

   logic [26:0] obs1, obs2;
   assign obs1 = {dv_o1, hs_o1, vs_o1, r_o1, g_o1, b_o1};
   assign obs2 = {dv_o2, hs_o2, vs_o2, r_o2, g_o2, b_o2};

   initial begin
      rst  = 1'b1;
      sel1 = '0;
      sel2 = '0;
      dv_i = '0; hs_i = '0; vs_i = '0;
      r_i  = '0; g_i  = '0; b_i  = '0;

      for (int j = 0; j < 712; j++) begin
         @(posedge clk);
         #1;
         case (j)
            4:   rst = 1'b0;
            30:  begin sel1 = 3'd2; sel2 = 3'd1; end
            80:  sel2 = 3'd3;
            160: sel1 = 3'd3;
            166: sel1 = 3'd2;
            210: sel1 = 3'd1;
            335: sel1 = 3'd3;
            460: sel1 = 3'd5;
            650: rst = 1'b1;
            651: begin rst = 1'b0; sel1 = 3'd0; end
            default: ;
         endcase
         drive(j);

         @(negedge clk);
         case (j)
            2: begin
               check("rst_out1", obs1, 32'h0);
               check("rst_out2", obs2, 32'h0);
               check("rst_fcnt", frame_cnt1, 32'h0);
               check("rst_act", active1, 32'h0);
               check("rst_flags", {pending1, blank1}, 32'h0);
            end
            20:  check("lat_sel0", obs1, stream_vec(0, 11));
            33: begin
               check("pend_set", pending1, 32'h1);
               check("pend_act_hold", active1, 32'h0);
            end
            56: begin
               check("pre_bnd_out", obs1, stream_vec(0, 47));
               check("pre_bnd_fcnt", frame_cnt1, 32'h0);
            end
            57: begin
               check("sw_act", active1, 32'h2);
               check("sw_blank", blank1, 32'h1);
               check("sw_pend_clr", pending1, 32'h0);
               check("sw_fcnt", frame_cnt1, 32'h1);
               check("sw_out_black", obs1, black(stream_vec(2, 48)));
               check("b2_act1", active2, 32'h1);
               check("b2_blank1", blank2, 32'h1);
               check("b2_pend_clr", pending2, 32'h0);
            end
            100: check("blank_frame", obs1, black(stream_vec(2, 91)));
            121: begin
               check("unblank", blank1, 32'h0);
               check("fcnt2", frame_cnt1, 32'h2);
               check("sel2_first", obs1, stream_vec(2, 112));
               check("b2_act3", active2, 32'h3);
               check("b2_reload", blank2, 32'h1);
            end
            150: check("lat_sel2", obs1, stream_vec(2, 141));
            165: check("cancel_pend", pending1, 32'h1);
            170: check("cancel_clr", pending1, 32'h0);
            185: begin
               check("cancel_fcnt", frame_cnt1, 32'h3);
               check("cancel_act", active1, 32'h2);
               check("cancel_noblank", blank1, 32'h0);
               check("b2_second_blank", blank2, 32'h1);
            end
            200: check("cancel_out", obs1, stream_vec(2, 191));
            215: check("b2_black", obs2, black(stream_vec(3, 206)));
            249: begin
               check("b2_unblank", blank2, 32'h0);
               check("b2_out3", obs2, stream_vec(3, 240));
               check("b2_fcnt", frame_cnt2, 32'h4);
               check("sw1_act", active1, 32'h1);
               check("sw1_blank", blank1, 32'h1);
            end
            260: check("b2_lat3", obs2, stream_vec(3, 251));
            330: begin
               check("lat_sel1", obs1, stream_vec(1, 321));
               check("sel1_noblank", blank1, 32'h0);
            end
            377: begin
               check("sw3_act", active1, 32'h3);
               check("sw3_blank", blank1, 32'h1);
            end
            450: check("lat_sel3", obs1, stream_vec(3, 441));
            505: begin
               check("inv_act", active1, 32'h5);
               check("inv_blank", blank1, 32'h1);
               check("inv_out_bnd", obs1, black(stream_vec(0, 496)));
            end
            580: begin
               check("inv_noblank", blank1, 32'h0);
               check("inv_out_vs", obs1, black(stream_vec(0, 571)));
            end
            600: begin
               check("inv_out_dv", obs1, black(stream_vec(0, 591)));
               check("inv_act_hold", active1, 32'h5);
            end
            610: begin
               check("fcnt9", frame_cnt1, 32'h9);
               force u_dut1.frame_cnt_q = 16'hFFFF;
            end
            611: release u_dut1.frame_cnt_q;
            620: check("fcnt_preload", frame_cnt1, 32'hFFFF);
            633: check("fcnt_wrap", frame_cnt1, 32'h0);
            651: begin
               check("mid_rst_out", obs1, 32'h0);
               check("mid_rst_act", active1, 32'h0);
               check("mid_rst_fcnt", frame_cnt1, 32'h0);
               check("mid_rst_flags", {pending1, blank1}, 32'h0);
            end
            670: begin
               check("post_rst_out", obs1, stream_vec(0, 661));
               check("post_rst_pend", pending1, 32'h0);
            end
            697: check("post_rst_fcnt", frame_cnt1, 32'h1);
            default: ;
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/video_path_select.md
Name: video_path_select

Overview:
- Parametrised successor to the fixed rx -> rgb2y -> fir_filter -> tx chain: selects one of N_IN processed video streams for the HDMI transmitter, all sharing the rx pixel clock.
- Compensates each stream's processing latency with per-input delay lines, so every selection is output with identical timing.
- Switches source only at a frame boundary, then blanks the picture for a programmable number of frames.
- Sits between the processing paths (bypass, luma, FIR, ...) and hdmi_tx; sel_i is driven from the board switches.

Parameters:
- DW, 8, bits per colour channel.
- N_IN, 4, number of input streams (2..8).
- LAT, {8'd0,8'd0,8'd0,8'd0}, packed N_IN x 8-bit; LAT[k] is stream k's latency in clocks relative to the common source.
- LAT_MAX, 16, alignment target; must be >= every LAT[k] (elaboration error otherwise).
- VS_POL, 1, active level of vs.
- BLANK_FRAMES, 1, frames forced black after a switch (0 disables blanking).
- SW, $clog2(N_IN+1), width of sel_i.

Ports:
- clk  in  1  pixel clock (rx_clk)
- rst  in  1  synchronous, active-high reset
- dv_i  in  N_IN  data valid, bit k = stream k
- hs_i  in  N_IN  hsync per stream
- vs_i  in  N_IN  vsync per stream
- r_i  in  N_IN*DW  red, stream k at [k*DW +: DW]
- g_i  in  N_IN*DW  green, same packing
- b_i  in  N_IN*DW  blue, same packing
- sel_i  in  SW  requested stream; values >= N_IN mean "black"
- dv_o  out  1  selected data valid
- hs_o  out  1  selected hsync
- vs_o  out  1  selected vsync
- r_o  out  DW  selected red
- g_o  out  DW  selected green
- b_o  out  DW  selected blue
- active_sel_o  out  SW  currently applied selection
- pending_o  out  1  switch requested, not yet applied
- blank_o  out  1  output currently forced black
- frame_cnt_o  out  16  frame boundaries seen since reset

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; active_sel=0; pending=0; blank counter=0; frame_cnt=0; all delay-line contents cleared to 0.
- Alignment:
  - Stream k passes through a shift register of depth D_k = LAT_MAX - LAT[k], width 3+3*DW.
  - D_k=0 means a direct wire.
- Output register:
  - One register stage follows the mux.
  - Total latency from stream k's inputs to the outputs = D_k + 1 clocks.
- Frame boundary:
  - Detected on aligned stream 0 only: vs0_a == VS_POL while the registered previous vs0_a != VS_POL.
  - Aligned vs of all streams coincides by construction.
- Selection request:
  - sel_i is registered once into sel_q.
  - pending = (sel_q != active_sel), re-evaluated every cycle.
  - If sel_q returns to active_sel before a boundary, pending clears and no switch occurs.
- Boundary cycle with pending=1:
  - active_sel <= sel_q.
  - The output register on that same edge already loads from the new source.
  - blank counter <= BLANK_FRAMES.
  - pending clears.
- Boundary cycle with pending=0 and blank counter > 0: counter decrements.
- Blanking:
  - blank_o = (blank counter != 0).
  - While blanked, dv/hs/vs come from the selected aligned stream; r/g/b are 0.
  - A new switch during blanking reloads the counter to BLANK_FRAMES.
- Invalid selection (active_sel >= N_IN):
  - dv/hs/vs are taken from aligned stream 0; r/g/b are 0.
  - blank_o follows the counter only.
- frame_cnt increments on every boundary, whether or not a switch occurs; wraps 0xFFFF -> 0.
- rst asserted mid-frame: reset values take effect next edge. After release, output shows stream 0 immediately; the first boundary then counts normally.

Test Plan:
- Reset/latency: N_IN=4, LAT={0,3,5,8}, LAT_MAX=8, all streams driven by one ramp generator with a per-stream delay of LAT[k]. Required: with sel=1, outputs equal the source ramp delayed 9 clocks, and likewise for sel=0,2,3 (always 9 clocks). After rst, all outputs and frame_cnt_o are 0.
- Frame-synchronous switch: in mid-frame of frame N, set sel 0 -> 2. Required: pending_o=1 until the first aligned vs0 edge. At the output cycle of that edge, active_sel_o=2 and blank_o=1. Frame N+1 is output black with valid syncs; stream 2 pixels appear from frame N+2.
- Cancelled request: sel 0 -> 3 -> 0, all within one frame. Required: pending_o pulses then returns to 0; no switch, no blanking; frame_cnt_o still increments at the boundary.
- Re-switch during blank, with BLANK_FRAMES=2: switch 0->1, then 1->3 one frame later. Required: the counter reloads at the second boundary, and black lasts two frames after the 1->3 switch.
- Invalid selection: sel=5. Required: after the boundary, active_sel_o=5, r/g/b=0, and syncs match aligned stream 0 exactly.
- Counter wrap: preload the bench to 65535 boundaries (or force). Required: the next boundary gives frame_cnt_o=0. Also assert rst mid-frame: the following edge gives active_sel_o=0 and frame_cnt_o=0.
